// File: rtl/oldest2_req_queue.sv
// Age-ordered circular request queue feeding the oldest-two arbiter; up to two
// allocations and two grants per cycle, registered two-lane issue. Optional perf
// counters under OLDEST2_REQ_QUEUE_PERF_EN.
module oldest2_req_queue #(
  parameter int SEL_WIDTH      = 16,
  parameter int PRIORITY_WIDTH = 4,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc0_vld_i,
  input  logic [DATA_WIDTH-1:0]     alloc0_data_i,
  input  logic                      alloc1_vld_i,
  input  logic [DATA_WIDTH-1:0]     alloc1_data_i,
  output logic                      alloc_rdy_o,
  input  logic                      issue_stall_i,
  output logic [SEL_WIDTH-1:0]      req_o,
  output logic [PRIORITY_WIDTH-1:0] priority_fix_o,
  output logic                      new_req_first_o,
  output logic                      new_req_second_o,
  input  logic                      first_grant_valid_i,
  input  logic [PRIORITY_WIDTH-1:0] first_grant_index_i,
  input  logic                      second_grant_valid_i,
  input  logic [PRIORITY_WIDTH-1:0] second_grant_index_i,
  output logic                      issue0_vld_o,
  output logic [PRIORITY_WIDTH-1:0] issue0_idx_o,
  output logic [DATA_WIDTH-1:0]     issue0_data_o,
  output logic                      issue1_vld_o,
  output logic [PRIORITY_WIDTH-1:0] issue1_idx_o,
  output logic [DATA_WIDTH-1:0]     issue1_data_o
`ifdef OLDEST2_REQ_QUEUE_PERF_EN
  ,
  output logic [31:0]               perf_issue_cnt_o,
  output logic [31:0]               perf_full_cyc_o
`endif
);
  localparam int PW = PRIORITY_WIDTH;

  logic [SEL_WIDTH-1:0]                 valid_q, valid_d, valid_clr, clr;
  logic [SEL_WIDTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [PW:0]                          head_q, head_d, tail_q, tail_d, span, head_off;
  logic [PW-1:0]                        slot, wslot;
  logic                                 g0_eff, g1_eff, alloc_ok;
  logic                                 i0_vld_q, i0_vld_d, i1_vld_q, i1_vld_d;
  logic [PW-1:0]                        i0_idx_q, i0_idx_d, i1_idx_q, i1_idx_d;
  logic [DATA_WIDTH-1:0]                i0_data_q, i0_data_d, i1_data_q, i1_data_d;

  assign span     = tail_q - head_q;
  assign alloc_ok = (int'(span) <= SEL_WIDTH - 2);

  // A repeated index on the second grant would double-issue one entry.
  assign g0_eff = !issue_stall_i && first_grant_valid_i && valid_q[first_grant_index_i];
  assign g1_eff = !issue_stall_i && second_grant_valid_i && valid_q[second_grant_index_i] &&
                  !(first_grant_valid_i && (second_grant_index_i == first_grant_index_i));

  always_comb begin
    clr = '0;
    if (g0_eff) clr[first_grant_index_i] = 1'b1;
    if (g1_eff) clr[second_grant_index_i] = 1'b1;
    valid_clr = valid_q & ~clr;

    // Head lands on the oldest surviving entry, or on tail when none remain.
    head_off = span;
    slot     = '0;
    for (int i = SEL_WIDTH - 1; i >= 0; i--) begin
      slot = head_q[PW-1:0] + PW'(i);
      if ((i < int'(span)) && valid_clr[slot]) head_off = (PW+1)'(i);
    end
    head_d = head_q + head_off;

    valid_d = valid_clr;
    data_d  = data_q;
    tail_d  = tail_q;
    wslot   = tail_q[PW-1:0];
    if (alloc_ok) begin
      if (alloc0_vld_i) begin
        valid_d[wslot] = 1'b1;
        data_d[wslot]  = alloc0_data_i;
        wslot          = wslot + 1'b1;
      end
      if (alloc1_vld_i) begin
        valid_d[wslot] = 1'b1;
        data_d[wslot]  = alloc1_data_i;
      end
      tail_d = tail_q + (PW+1)'(alloc0_vld_i) + (PW+1)'(alloc1_vld_i);
    end

    i0_vld_d  = g0_eff;
    i0_idx_d  = g0_eff ? first_grant_index_i : '0;
    i0_data_d = g0_eff ? data_q[first_grant_index_i] : '0;
    i1_vld_d  = g1_eff;
    i1_idx_d  = g1_eff ? second_grant_index_i : '0;
    i1_data_d = g1_eff ? data_q[second_grant_index_i] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      i0_vld_q  <= 1'b0;
      i0_idx_q  <= '0;
      i0_data_q <= '0;
      i1_vld_q  <= 1'b0;
      i1_idx_q  <= '0;
      i1_data_q <= '0;
    end else begin
      valid_q   <= valid_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      i0_vld_q  <= i0_vld_d;
      i0_idx_q  <= i0_idx_d;
      i0_data_q <= i0_data_d;
      i1_vld_q  <= i1_vld_d;
      i1_idx_q  <= i1_idx_d;
      i1_data_q <= i1_data_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) data_q <= data_d;

  assign alloc_rdy_o      = alloc_ok;
  assign req_o            = valid_q;
  assign priority_fix_o   = head_q[PW-1:0];
  assign new_req_first_o  = !issue_stall_i;
  assign new_req_second_o = !issue_stall_i;
  assign issue0_vld_o     = i0_vld_q;
  assign issue0_idx_o     = i0_idx_q;
  assign issue0_data_o    = i0_data_q;
  assign issue1_vld_o     = i1_vld_q;
  assign issue1_idx_o     = i1_idx_q;
  assign issue1_data_o    = i1_data_q;

`ifdef OLDEST2_REQ_QUEUE_PERF_EN
  logic [31:0] perf_issue_cnt_q, perf_issue_cnt_d, perf_full_cyc_q, perf_full_cyc_d;
  logic [32:0] issue_sum;

  always_comb begin
    issue_sum        = {1'b0, perf_issue_cnt_q} + 33'(i0_vld_q) + 33'(i1_vld_q);
    perf_issue_cnt_d = issue_sum[32] ? '1 : issue_sum[31:0];
    perf_full_cyc_d  = perf_full_cyc_q;
    if ((int'(span) == SEL_WIDTH) && (perf_full_cyc_q != '1))
      perf_full_cyc_d = perf_full_cyc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_cnt_q <= '0;
      perf_full_cyc_q  <= '0;
    end else begin
      perf_issue_cnt_q <= perf_issue_cnt_d;
      perf_full_cyc_q  <= perf_full_cyc_d;
    end
  end

  assign perf_issue_cnt_o = perf_issue_cnt_q;
  assign perf_full_cyc_o  = perf_full_cyc_q;
`endif
endmodule

// File: tb/tb_oldest2_req_queue.sv
// Directed bench for oldest2_req_queue: stimulus pushes expected issues into a
// scoreboard, a negedge monitor pops and compares whenever an issue lane is valid.
module tb_oldest2_req_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        alloc0_vld_i, alloc1_vld_i, alloc_rdy_o, issue_stall_i;
  logic [31:0] alloc0_data_i, alloc1_data_i;
  logic [15:0] req_o;
  logic [3:0]  priority_fix_o;
  logic        new_req_first_o, new_req_second_o;
  logic        first_grant_valid_i, second_grant_valid_i;
  logic [3:0]  first_grant_index_i, second_grant_index_i;
  logic        issue0_vld_o, issue1_vld_o;
  logic [3:0]  issue0_idx_o, issue1_idx_o;
  logic [31:0] issue0_data_o, issue1_data_o;

  oldest2_req_queue dut (
    .clk(clk), .rst(rst),
    .alloc0_vld_i(alloc0_vld_i), .alloc0_data_i(alloc0_data_i),
    .alloc1_vld_i(alloc1_vld_i), .alloc1_data_i(alloc1_data_i),
    .alloc_rdy_o(alloc_rdy_o), .issue_stall_i(issue_stall_i),
    .req_o(req_o), .priority_fix_o(priority_fix_o),
    .new_req_first_o(new_req_first_o), .new_req_second_o(new_req_second_o),
    .first_grant_valid_i(first_grant_valid_i), .first_grant_index_i(first_grant_index_i),
    .second_grant_valid_i(second_grant_valid_i), .second_grant_index_i(second_grant_index_i),
    .issue0_vld_o(issue0_vld_o), .issue0_idx_o(issue0_idx_o), .issue0_data_o(issue0_data_o),
    .issue1_vld_o(issue1_vld_o), .issue1_idx_o(issue1_idx_o), .issue1_data_o(issue1_data_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v0; logic [3:0] i0; logic [31:0] d0;
    logic        v1; logic [3:0] i1; logic [31:0] d1;
  } exp_t;

  exp_t        sb[$];
  int          n_pass = 0, n_total = 0;
  logic [31:0] m_data [16];
  logic [3:0]  m_tail = 4'd0;
  logic [7:0]  seq = 8'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One cycle: allocs (acc = expected to be accepted), stall, grants, and which
  // lanes are expected to issue on the following cycle.
  task automatic cyc(input bit a0, input bit a1, input bit acc, input bit st,
                     input bit g0v, input logic [3:0] g0, input bit g1v, input logic [3:0] g1,
                     input bit x0, input bit x1);
    exp_t e;
    logic [31:0] d0, d1;
    logic [3:0]  s;
    seq++;
    s  = m_tail;
    d0 = {8'hA0, seq, 12'h000, s};
    d1 = {8'hB1, seq, 12'h000, (a0 ? s + 4'd1 : s)};
    e.v0 = x0; e.i0 = x0 ? g0 : 4'd0; e.d0 = x0 ? m_data[g0] : 32'd0;
    e.v1 = x1; e.i1 = x1 ? g1 : 4'd0; e.d1 = x1 ? m_data[g1] : 32'd0;
    if (x0 || x1) sb.push_back(e);
    if (acc) begin
      if (a0) begin m_data[m_tail] = d0; m_tail = m_tail + 4'd1; end
      if (a1) begin m_data[m_tail] = d1; m_tail = m_tail + 4'd1; end
    end
    alloc0_vld_i = a0; alloc0_data_i = d0;
    alloc1_vld_i = a1; alloc1_data_i = d1;
    issue_stall_i = st;
    first_grant_valid_i = g0v;  first_grant_index_i = g0;
    second_grant_valid_i = g1v; second_grant_index_i = g1;
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst && (issue0_vld_o || issue1_vld_o)) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL phantom_issue: got lanes %0b%0b idx %0d/%0d expected none",
                 issue0_vld_o, issue1_vld_o, issue0_idx_o, issue1_idx_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("issue0", 64'({issue0_vld_o, issue0_idx_o, issue0_data_o}), 64'({e.v0, e.i0, e.d0}));
        check("issue1", 64'({issue1_vld_o, issue1_idx_o, issue1_data_o}), 64'({e.v1, e.i1, e.d1}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (2) begin
      alloc0_vld_i = 1'($urandom); alloc0_data_i = $urandom;
      alloc1_vld_i = 1'($urandom); alloc1_data_i = $urandom;
      issue_stall_i = 1'($urandom);
      first_grant_valid_i = 1'($urandom);  first_grant_index_i = 4'($urandom);
      second_grant_valid_i = 1'($urandom); second_grant_index_i = 4'($urandom);
      tick();
    end
    rst = 1'b0;
    alloc0_vld_i = 0; alloc1_vld_i = 0; issue_stall_i = 0;
    first_grant_valid_i = 0; second_grant_valid_i = 0;
    check("rst_req", 64'(req_o), 64'h0);
    check("rst_pf", 64'(priority_fix_o), 64'h0);
    check("rst_rdy", 64'(alloc_rdy_o), 64'h1);
    check("rst_i0", 64'(issue0_vld_o), 64'h0);
    check("rst_i1", 64'(issue1_vld_o), 64'h0);

    // Fill under stall while presenting grants that must be ignored
    for (int p = 0; p < 8; p++) begin
      cyc(1, 1, 1, 1, 1, 4'd0, 1, 4'd1, 0, 0);
      check("fill_rdy", 64'(alloc_rdy_o), 64'(p < 7));
    end
    check("stall_nrf", 64'({new_req_first_o, new_req_second_o}), 64'h0);
    check("full_req", 64'(req_o), 64'hFFFF);
    check("full_pf", 64'(priority_fix_o), 64'h0);
    cyc(1, 1, 0, 1, 0, 4'd0, 0, 4'd0, 0, 0);
    check("drop_req", 64'(req_o), 64'hFFFF);
    check("drop_rdy", 64'(alloc_rdy_o), 64'h0);

    cyc(0, 0, 0, 0, 1, 4'd0, 1, 4'd1, 1, 1);
    check("g01_req", 64'(req_o), 64'hFFFC);
    check("g01_pf", 64'(priority_fix_o), 64'h2);
    check("g01_rdy", 64'(alloc_rdy_o), 64'h1);
    check("nostall_nrf", 64'({new_req_first_o, new_req_second_o}), 64'h3);

    cyc(0, 0, 0, 0, 1, 4'd5, 0, 4'd0, 1, 0);
    check("hole_req", 64'(req_o), 64'hFFDC);
    check("hole_pf", 64'(priority_fix_o), 64'h2);
    cyc(0, 0, 0, 0, 1, 4'd5, 1, 4'd5, 0, 0);
    check("inval_req", 64'(req_o), 64'hFFDC);
    cyc(0, 0, 0, 0, 1, 4'd2, 1, 4'd2, 1, 0);
    check("dup_req", 64'(req_o), 64'hFFD8);
    check("dup_pf", 64'(priority_fix_o), 64'h3);
    cyc(0, 0, 0, 0, 1, 4'd4, 1, 4'd6, 1, 1);
    check("g46_req", 64'(req_o), 64'hFF88);
    check("g46_pf", 64'(priority_fix_o), 64'h3);
    cyc(0, 0, 0, 0, 1, 4'd3, 0, 4'd0, 1, 0);
    check("skip_req", 64'(req_o), 64'hFF80);
    check("skip_pf", 64'(priority_fix_o), 64'h7);
    cyc(0, 0, 0, 1, 1, 4'd7, 1, 4'd8, 0, 0);
    check("stall_req", 64'(req_o), 64'hFF80);
    check("stall_pf", 64'(priority_fix_o), 64'h7);

    for (int k = 7; k < 15; k += 2) cyc(0, 0, 0, 0, 1, 4'(k), 1, 4'(k + 1), 1, 1);
    cyc(0, 0, 0, 0, 1, 4'd15, 0, 4'd0, 1, 0);
    check("empty_req", 64'(req_o), 64'h0);
    check("empty_pf", 64'(priority_fix_o), 64'h0);

    repeat (7) cyc(1, 1, 1, 0, 0, 4'd0, 0, 4'd0, 0, 0);
    check("refill_req", 64'(req_o), 64'h3FFF);
    check("refill_rdy", 64'(alloc_rdy_o), 64'h1);
    for (int k = 0; k < 14; k += 2) cyc(0, 0, 0, 0, 1, 4'(k), 1, 4'(k + 1), 1, 1);
    check("drain_req", 64'(req_o), 64'h0);
    check("drain_pf", 64'(priority_fix_o), 64'hE);

    repeat (2) cyc(1, 1, 1, 0, 0, 4'd0, 0, 4'd0, 0, 0);
    check("wrap_req", 64'(req_o), 64'hC003);
    check("wrap_pf", 64'(priority_fix_o), 64'hE);
    cyc(0, 1, 1, 0, 1, 4'd14, 1, 4'd15, 1, 1);
    check("wrapg_req", 64'(req_o), 64'h0007);
    check("wrapg_pf", 64'(priority_fix_o), 64'h0);
    cyc(0, 0, 0, 0, 1, 4'd0, 1, 4'd1, 1, 1);
    check("wrap01_req", 64'(req_o), 64'h0004);
    check("wrap01_pf", 64'(priority_fix_o), 64'h2);
    cyc(0, 0, 0, 0, 0, 4'd0, 1, 4'd2, 0, 1);
    check("fin_req", 64'(req_o), 64'h0);
    check("fin_pf", 64'(priority_fix_o), 64'h3);
    check("fin_rdy", 64'(alloc_rdy_o), 64'h1);

    cyc(0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0);
    tick();
    check("sb_empty", 64'(sb.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/oldest2_req_queue.md
Name: oldest2_req_queue

Overview:
- Circular request queue that directly feeds oldest2_abitter_bps.
- Entries are allocated in age order at a tail pointer, up to two per cycle.
- Each cycle the block drives the arbiter's req vector and priority_fix (the oldest-entry pointer), then consumes the two grants.
- Granted entries are issued to a registered two-lane output and freed out of order; the head advances past freed holes.

Parameters:
- SEL_WIDTH, 16, number of entries; must be a power of two, at least 4.
- PRIORITY_WIDTH, 4, log2(SEL_WIDTH); width of indices and priority_fix.
- DATA_WIDTH, 32, payload bits stored per entry.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- alloc0_vld_i  in  1  allocate the older new entry.
- alloc0_data_i  in  DATA_WIDTH  its payload.
- alloc1_vld_i  in  1  allocate the younger new entry.
- alloc1_data_i  in  DATA_WIDTH  its payload.
- alloc_rdy_o  out  1  room for two allocations this cycle.
- issue_stall_i  in  1  downstream cannot accept issues.
- req_o  out  SEL_WIDTH  valid-entry bitmap, goes to arbiter req_i.
- priority_fix_o  out  PRIORITY_WIDTH  head index, goes to arbiter priority_fix_i.
- new_req_first_o  out  1  goes to arbiter new_req_first_i.
- new_req_second_o  out  1  goes to arbiter new_req_second_i.
- first_grant_valid_i  in  1  from arbiter.
- first_grant_index_i  in  PRIORITY_WIDTH  from arbiter.
- second_grant_valid_i  in  1  from arbiter.
- second_grant_index_i  in  PRIORITY_WIDTH  from arbiter.
- issue0_vld_o  out  1  registered issue, older lane.
- issue0_idx_o  out  PRIORITY_WIDTH  entry index of lane 0.
- issue0_data_o  out  DATA_WIDTH  payload of lane 0.
- issue1_vld_o  out  1  registered issue, younger lane.
- issue1_idx_o  out  PRIORITY_WIDTH  entry index of lane 1.
- issue1_data_o  out  DATA_WIDTH  payload of lane 1.

Behaviour:
- Interface: one clock clk; reset rst is synchronous, active-high.
- State:
  - valid[SEL_WIDTH] and data[SEL_WIDTH].
  - head and tail pointers, each PRIORITY_WIDTH+1 bits; the MSB is the wrap bit.
  - span = tail - head, range 0..SEL_WIDTH, holes included.
- Reset (clock edge with rst=1):
  - valid=0, head=tail=0.
  - All issue outputs 0.
  - The first cycle after reset shows req_o=0, priority_fix_o=0, alloc_rdy_o=1.
  - Reset mid-operation discards all entries, including any issue in flight.
- req_o = valid (combinational from state). priority_fix_o = head[PRIORITY_WIDTH-1:0].
- new_req_first_o = new_req_second_o = !issue_stall_i.
- Allocation:
  - alloc_rdy_o = (span <= SEL_WIDTH-2).
  - Allocation is accepted only when alloc_rdy_o=1. Unaccepted requests are dropped and the source must hold them.
  - alloc0 writes slot tail, alloc1 writes slot tail+1, tail += count.
  - alloc1 without alloc0 writes slot tail, tail += 1.
  - New entries become valid on the next cycle; they are never granted in their allocation cycle.
- Grant consumption (grant inputs are combinational from the arbiter in the same cycle):
  - A grant is effective if issue_stall_i=0, its valid is 1, and valid[index]=1.
  - If second index equals first index, the second grant is ignored.
  - Each effective grant clears valid[index] at the edge.
- Issue:
  - Registered; effective first/second grants appear on lanes 0/1 the cycle after, with that entry's index and data.
  - Lanes with no effective grant drive vld=0; idx/data are don't-care but held at 0.
- Head update at each edge:
  - Considers valid after clears and before allocations.
  - Head moves to the first still-valid slot scanning from head toward tail, stopping at tail.
  - If no valid slot remains, head = tail (queue empty, span 0).
  - Head never passes tail.
- Simultaneous events: allocation, grant clears, head advance and tail advance all occur in the same cycle. A slot freed by head advance is reusable by allocation the next cycle, not the same cycle.
- Full: span = SEL_WIDTH gives alloc_rdy_o=0. Issuing continues normally.
- Wrap-around: pointers wrap modulo 2*SEL_WIDTH. Index bits wrap modulo SEL_WIDTH.

Optional Feature:
- Macro: OLDEST2_REQ_QUEUE_PERF_EN.
- Defined:
  - Adds output perf_issue_cnt_o [31:0], counting issued lanes: +0, +1 or +2 per cycle, based on the registered issue valids.
  - Adds output perf_full_cyc_o [31:0], counting cycles with span = SEL_WIDTH.
  - Both reset to 0 and saturate at all-ones.
- Not defined: neither port nor either counter exists; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random inputs -> req_o=0, priority_fix_o=0, alloc_rdy_o=1, issue0_vld_o=issue1_vld_o=0.
- Fill: stall=1, two allocs per cycle with data=slot index for 8 cycles -> alloc_rdy_o=1 through the 7th pair (span 14), 0 after the 8th; req_o=16'hFFFF.
- In-order issue: from full, grants 0 and 1 -> next cycle issue0 {idx 0, data 0}, issue1 {idx 1, data 1}; req_o=16'hFFFC; priority_fix_o=2; alloc_rdy_o=1.
- Out-of-order hole: head=2, single grant index 5 -> issue0 idx 5, bit 5 cleared, priority_fix_o stays 2. Later grants 2,3 -> priority_fix_o=4. Grants 4,6 -> priority_fix_o=7 (skips hole 5).
- Wrap: head=14, tail=14, alloc two per cycle for 2 cycles -> slots 14,15,0,1 valid, tail=18 (wrap bit set, index 2); granting 14,15 -> priority_fix_o=0.
- Illegal and stall cases: grant to an invalid slot, duplicate first/second index, or any grant with issue_stall_i=1 -> no state change beyond expected, and no duplicate or phantom issue.
